divider_32bit: RTL and testbench
================================

// Module: divider_32bit
// PURPOSE
//   Multi-cycle 32-bit integer divider; the subtractive counterpart to Adder_32bit.
//   Implements RV32M DIV/DIVU/REM/REMU via restoring shift-subtract, one quotient bit per clock.
//   Sits beside the ALU; core presents operands with a valid/ready handshake, stalls until out_valid.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; iteration count equals WIDTH
// PORTS
//   clk        in   1      single clock, all state updates on rising edge
//   reset      in   1      synchronous, active-high; sampled on rising edge of clk
//   in_valid   in   1      operands/op presented this cycle
//   in_ready   out  1      divider idle, can accept an operation
//   dividend   in   WIDTH  operand a (rs1)
//   divisor    in   WIDTH  operand b (rs2)
//   is_signed  in   1      1: DIV/REM two's-complement; 0: DIVU/REMU unsigned
//   want_rem   in   1      1: result is remainder; 0: result is quotient
//   out_valid  out  1      result valid; held until accepted
//   out_ready  in   1      consumer takes result this cycle
//   result     out  WIDTH  quotient or remainder
// BEHAVIOUR
//   Reset: state=IDLE, in_ready=1, out_valid=0, result=0, iteration counter=0, internal regs cleared.
//   Reset mid-operation: operation discarded, same reset values next cycle; nothing is emitted.
//   States: IDLE -> CALC -> DONE -> IDLE; IDLE -> DONE directly for special cases.
//   in_ready = (state==IDLE); out_valid = (state==DONE); both registered-state derived, no comb path from inputs.
//   Accept: edge with in_valid && in_ready captures dividend, divisor, is_signed, want_rem;
//     operand changes after acceptance are ignored.
//   Special cases, decided at accept, go IDLE -> DONE (out_valid in the cycle after accept edge):
//     divisor==0: quotient=all ones, remainder=dividend (both signed and unsigned).
//     is_signed && dividend==0x80000000 && divisor==0xFFFFFFFF: quotient=0x80000000, remainder=0.
//   Normal path: at accept, take magnitudes (abs when is_signed), record quotient sign
//     (dividend sign XOR divisor sign) and remainder sign (dividend sign); go to CALC, counter=0.
//   CALC: each edge shift {rem,quo} left 1, trial = rem - |divisor| (WIDTH+1 bit subtract);
//     if trial non-negative keep it and set quotient LSB=1, else restore and LSB=0; counter++.
//   On the WIDTH-th CALC edge: apply sign correction (two's-complement negate when sign set),
//     select quotient or remainder per want_rem, register into result, go to DONE.
//   Latency: out_valid first high in the cycle after the WIDTH-th rising edge following accept
//     (32 edges for WIDTH=32); special cases: 1 edge.
//   Semantics: truncation toward zero; nonzero remainder carries dividend sign; |rem| < |divisor|.
//   DONE: result and out_valid held stable while out_ready=0 (unbounded backpressure).
//     Edge with out_ready=1: go IDLE, out_valid=0; result keeps last value. in_ready low in DONE,
//     so no accept on the same edge as result hand-off; earliest new accept is the next edge.
//   in_valid while busy (CALC/DONE) is ignored; core must hold it until in_ready.
//   No pipelining: one operation in flight at a time.
// TESTING
//   DIVU 100/7, want_rem=0 -> result=14 after 32 edges; same with want_rem=1 -> result=2.
//   DIV -7/2 (0xFFFFFFF9/2) -> quotient 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
//   DIVU/REMU 0x1234/0 -> quotient 0xFFFFFFFF, remainder 0x1234, out_valid one edge after accept.
//   DIV 0x80000000/0xFFFFFFFF signed -> quotient 0x80000000, REM 0, one-edge latency;
//     same operands unsigned -> quotient 0, remainder 0x80000000 via full 32 iterations.
//   Hold out_ready=0 for 5 cycles in DONE -> result/out_valid stable, in_ready=0; on accept,
//     next cycle in_ready=1, back-to-back op 0xFFFFFFFF/0x10 DIVU -> 0x0FFFFFFF.
//   Assert reset on the 10th CALC cycle -> next cycle in_ready=1, out_valid=0, result=0;
//     subsequent DIVU 1000/10 returns 100 with normal 32-edge latency.

Source files
------------

// File: rtl/divider_32bit.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Divide-by-zero and signed overflow are resolved at accept and skip the iteration loop.
module divider_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    input  logic             want_rem,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_want_rem;
    logic [WIDTH-1:0] r_result;

    logic             w_accept;
    logic             w_div_zero;
    logic             w_overflow;
    logic             w_special;
    logic             w_last;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_quo_fix;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;

    assign w_accept   = in_valid && (r_state == S_IDLE);
    assign w_div_zero = (divisor == '0);
    assign w_overflow = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
    assign w_special  = w_div_zero || w_overflow;
    assign w_last     = (r_count == CW'(WIDTH - 1));

    assign w_dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_dvs_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    // Partial remainder is always below the divisor, so the sign bit of a WIDTH+1 bit
    // difference is enough to tell whether the trial subtraction went negative.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_dvs};
    assign w_rem_next = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
    assign w_rem_fix  = r_r_neg ? -w_rem_next : w_rem_next;
    assign w_quo_fix  = r_q_neg ? -w_quo_next : w_quo_next;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: next state defaults to the current state so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = w_special ? S_DONE : S_CALC;
            S_CALC:  if (w_last) w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_want_rem <= 1'b0;
            r_result   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_want_rem <= want_rem;
                        r_count    <= '0;
                        if (w_div_zero) begin
                            r_result <= want_rem ? dividend : '1;
                        end else if (w_overflow) begin
                            r_result <= want_rem ? '0 : dividend;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= w_dvd_mag;
                            r_dvs   <= w_dvs_mag;
                            r_q_neg <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            r_r_neg <= is_signed && dividend[WIDTH-1];
                        end
                    end
                end
                S_CALC: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count + 1'b1;
                    if (w_last) r_result <= r_want_rem ? w_rem_fix : w_quo_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_32bit.sv
// Directed self-checking bench for divider_32bit: results, latency, backpressure,
// hand-off timing and mid-operation reset, against hand-computed values.
module tb_divider_32bit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        is_signed;
    logic        want_rem;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    divider_32bit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .is_signed (is_signed),
        .want_rem  (want_rem),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an operation, wait for the accept edge, then count edges until out_valid.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic r, output logic [31:0] res, output int n);
        int guard;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        want_rem  = r;
        in_valid  = 1'b1;
        guard     = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        dividend  = 32'hDEAD_BEEF;
        divisor   = 32'h0000_0005;
        is_signed = ~s;
        want_rem  = ~r;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        res = result;
    endtask

    task automatic handoff(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ho_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_ho_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic r, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int n;
        run_op(tag, a, b, s, r, res, n);
        check({tag, "_result"}, res, exp);
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        handoff(tag);
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] held;
        int n;

        reset     = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        want_rem  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Normal path: 32 edges after accept. Special cases: out_valid right after accept edge.
        op("divu_100_7",   32'd100,        32'd7,          1'b0, 1'b0, 32'd14,         32);
        op("remu_100_7",   32'd100,        32'd7,          1'b0, 1'b1, 32'd2,          32);
        op("div_m7_2",     32'hFFFF_FFF9,  32'd2,          1'b1, 1'b0, 32'hFFFF_FFFD,  32);
        op("rem_m7_2",     32'hFFFF_FFF9,  32'd2,          1'b1, 1'b1, 32'hFFFF_FFFF,  32);
        op("rem_7_m2",     32'd7,          32'hFFFF_FFFE,  1'b1, 1'b1, 32'd1,          32);
        op("div_7_m2",     32'd7,          32'hFFFF_FFFE,  1'b1, 1'b0, 32'hFFFF_FFFD,  32);
        op("divu_by0",     32'h0000_1234,  32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF,  0);
        op("remu_by0",     32'h0000_1234,  32'd0,          1'b0, 1'b1, 32'h0000_1234,  0);
        op("div_by0_s",    32'hFFFF_FFF9,  32'd0,          1'b1, 1'b0, 32'hFFFF_FFFF,  0);
        op("rem_by0_s",    32'hFFFF_FFF9,  32'd0,          1'b1, 1'b1, 32'hFFFF_FFF9,  0);
        op("div_ovf",      32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, 32'h8000_0000,  0);
        op("rem_ovf",      32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b1, 32'd0,          0);
        op("divu_ovfops",  32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b0, 32'd0,          32);
        op("remu_ovfops",  32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b1, 32'h8000_0000,  32);
        op("div_min_2",    32'h8000_0000,  32'd2,          1'b1, 1'b0, 32'hC000_0000,  32);
        op("divu_max_max", 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0, 32'd1,          32);
        op("remu_fe_ff",   32'hFFFF_FFFE,  32'hFFFF_FFFF,  1'b0, 1'b1, 32'hFFFF_FFFE,  32);

        // Backpressure: result held for 5 cycles, then hand-off with a new op already waiting.
        run_op("bp", 32'd1000, 32'd7, 1'b0, 1'b0, res, n);
        check("bp_result", res, 32'd142);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_result", result, 32'd142);
            check("bp_hold_out_valid", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dividend  = 32'hFFFF_FFFF;
        divisor   = 32'h0000_0010;
        is_signed = 1'b0;
        want_rem  = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        check("b2b_out_valid", 32'(out_valid), 32'd0);
        check("b2b_result_kept", result, 32'd142);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_busy", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_out_valid_rise", 32'(out_valid), 32'd1);
        check("b2b_result", result, 32'h0FFF_FFFF);
        check("b2b_latency", 32'(n), 32'd32);
        handoff("b2b");

        // Reset during the 10th CALC cycle discards the operation.
        @(negedge clk);
        dividend  = 32'h0000_FFFF;
        divisor   = 32'd3;
        is_signed = 1'b0;
        want_rem  = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        held = result;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("pre_rst_result_nonzero", 32'(held != 32'd0), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("post_rst_quiet", 32'(out_valid), 32'd0);
        op("divu_1000_10", 32'd1000, 32'd10, 1'b0, 1'b0, 32'd100, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
